// File: rtl/acc_drain_pkg.sv
// Shared constants and types for the accumulator drain stage: default widths,
// FSM encoding and int8 saturation limits.
package acc_drain_pkg;

  localparam int ACC_W_DEF   = 26;
  localparam int OUT_W_DEF   = 8;
  localparam int SHIFT_W_DEF = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_MAX_DEF = sat_max(OUT_W_DEF);
  localparam int SAT_MIN_DEF = sat_min(OUT_W_DEF);

endpackage

// File: rtl/acc_drain_requant_sat.sv
// Single-lane requantizer: arithmetic right shift with round-half-up, then
// saturate to OUT_W signed. Purely combinational; no flow control of its own.
module requant_sat
  import acc_drain_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic signed [ACC_W-1:0]   x_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic signed [OUT_W-1:0]   y_o,
  output logic                      sat_o
);

  // One guard bit so that adding the rounding constant to the most positive
  // accumulator cannot wrap.
  localparam int EXT_W = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] ONE   = EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(OUT_W));

  logic signed [EXT_W-1:0] x_ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    x_ext = {x_i[ACC_W-1], x_i};
    rnd   = '0;
    if (shift_i != '0) begin
      rnd = ONE << (shift_i - 1'b1);
    end
    sum     = x_ext + rnd;
    shifted = sum >>> shift_i;
  end

  always_comb begin
    y_o   = shifted[OUT_W-1:0];
    sat_o = 1'b0;
    if (shifted > MAX_V) begin
      y_o   = {1'b0, {(OUT_W-1){1'b1}}};
      sat_o = 1'b1;
    end else if (shifted < MIN_V) begin
      y_o   = {1'b1, {(OUT_W-1){1'b0}}};
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Snapshots NUM_LANES accumulators on start, streams them out requantized to int8
// one lane per valid/ready beat (lane 0 valid one cycle after start), then pulses acc_clear.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [NUM_LANES*ACC_W-1:0]     acc_in,
  input  logic [SHIFT_W-1:0]             shift,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUT_W-1:0]        out_data,
  output logic [$clog2(NUM_LANES)-1:0]   out_lane,
  output logic                           out_last,
  output logic                           sat_flag,
  output logic                           acc_clear
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(ACC_W - 1);

  state_e                  state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic signed [ACC_W-1:0] snap_q [NUM_LANES];
  logic signed [ACC_W-1:0] snap_d [NUM_LANES];
  logic                    sat_q, sat_d;
  logic                    clr_q, clr_d;

  logic [SHIFT_W-1:0]      shift_clamped;
  logic signed [ACC_W-1:0] lane_x;
  logic signed [OUT_W-1:0] lane_y;
  logic                    lane_sat;

  assign shift_clamped = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;

  // Output depends only on registered state, so stalls hold data steady and
  // acc_in is free to change once the snapshot is taken.
  assign lane_x = snap_q[lane_q];

  requant_sat #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .x_i     (lane_x),
    .shift_i (shift_q),
    .y_o     (lane_y),
    .sat_o   (lane_sat)
  );

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    snap_d  = snap_q;
    sat_d   = sat_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRAIN;
          lane_d  = '0;
          shift_d = shift_clamped;
          sat_d   = 1'b0;
          for (int i = 0; i < NUM_LANES; i++) begin
            snap_d[i] = acc_in[i*ACC_W +: ACC_W];
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          sat_d = sat_q | lane_sat;
          if (lane_q == LAST_LANE) begin
            state_d = ST_IDLE;
            lane_d  = '0;
            clr_d   = 1'b1;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      shift_q <= '0;
      sat_q   <= 1'b0;
      clr_q   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      sat_q   <= sat_d;
      clr_q   <= clr_d;
      snap_q  <= snap_d;
    end
  end

  assign busy      = (state_q == ST_DRAIN);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = lane_y;
  assign out_lane  = lane_q;
  assign out_last  = out_valid && (lane_q == LAST_LANE);
  assign sat_flag  = sat_q;
  assign acc_clear = clr_q;

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: per-scenario tasks with hand-computed int8 results.
module tb_acc_drain;

  localparam int NL = 4;
  localparam int AW = 26;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [NL*AW-1:0]  acc_in;
  logic [4:0]        shift;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic [1:0]        out_lane;
  logic              out_last;
  logic              sat_flag;
  logic              acc_clear;

  int errors = 0;
  int checks = 0;

  acc_drain #(.NUM_LANES(NL), .ACC_W(AW), .OUT_W(8), .SHIFT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .acc_in    (acc_in),
    .shift     (shift),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .sat_flag  (sat_flag),
    .acc_clear (acc_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int a, input int b, input int c, input int d);
    int v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < NL; i++) acc_in[i*AW +: AW] = AW'(v[i]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; shift = '0; acc_in = '0;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_lane !== 2'd0)  begin errors++; $display("FAIL reset_lane got %0d want 0", out_lane); end
    checks++; if (sat_flag !== 1'b0)  begin errors++; $display("FAIL reset_sat got %b want 0", sat_flag); end
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", acc_clear); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_shift();
    int exp_d [4];
    exp_d = '{6, -6, 1, 0};
    set_lanes(100, -100, 8, -8); shift = 5'd4; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid beat %0d got %b want 1", k, out_valid); end
      checks++; if (out_data !== 8'(exp_d[k])) begin errors++; $display("FAIL basic_data beat %0d got %0d want %0d", k, out_data, exp_d[k]); end
      checks++; if (out_lane !== 2'(k)) begin errors++; $display("FAIL basic_lane beat %0d got %0d want %0d", k, out_lane, k); end
      checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL basic_last beat %0d got %b want %b", k, out_last, (k == 3)); end
      checks++; if (acc_clear !== 1'b0) begin errors++; $display("FAIL basic_early_clr beat %0d got %b want 0", k, acc_clear); end
      tick();
    end
    checks++; if (acc_clear !== 1'b1) begin errors++; $display("FAIL basic_clr got %b want 1", acc_clear); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_idle got busy=%b want 0", busy); end
    checks++; if (sat_flag !== 1'b0)  begin errors++; $display("FAIL basic_sat got %b want 0", sat_flag); end
    tick();
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("FAIL basic_clr_pulse got %b want 0", acc_clear); end
  endtask

  task automatic test_saturation();
    int exp_d [4];
    exp_d = '{127, -128, 127, -128};
    set_lanes(40000, -33554432, 127, -128); shift = 5'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== 8'(exp_d[k])) begin errors++; $display("FAIL sat_data beat %0d got %0d want %0d", k, out_data, exp_d[k]); end
      tick();
      if (k == 1) begin
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_beat1 got %b want 1", sat_flag); end
      end
    end
    tick(); tick();
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_idle got %b want 1", sat_flag); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL sat_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_shift_clamp();
    int exp_d [4];
    exp_d = '{1, -1, 0, 0};
    set_lanes(33554431, -33554432, 0, 0); shift = 5'd31; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL clamp_sat_cleared got %b want 0", sat_flag); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== 8'(exp_d[k])) begin errors++; $display("FAIL clamp_data beat %0d got %0d want %0d", k, out_data, exp_d[k]); end
      tick();
    end
    tick();
  endtask

  task automatic test_backpressure();
    int exp_d [4];
    int drain_cycles;
    exp_d = '{31, 63, -94, 2};
    drain_cycles = 0;
    set_lanes(1000, 2000, -3000, 50); shift = 5'd5; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (busy === 1'b1) drain_cycles++;
      checks++; if (out_data !== 8'(exp_d[k])) begin errors++; $display("FAIL bp_data beat %0d got %0d want %0d", k, out_data, exp_d[k]); end
      tick();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (busy === 1'b1) drain_cycles++;
      acc_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      checks++; if (out_data !== 8'(exp_d[2])) begin errors++; $display("FAIL bp_hold_data stall %0d got %0d want %0d", s, out_data, exp_d[2]); end
      checks++; if (out_lane !== 2'd2) begin errors++; $display("FAIL bp_hold_lane stall %0d got %0d want 2", s, out_lane); end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      if (busy === 1'b1) drain_cycles++;
      checks++; if (out_data !== 8'(exp_d[k])) begin errors++; $display("FAIL bp_data beat %0d got %0d want %0d", k, out_data, exp_d[k]); end
      tick();
    end
    if (busy === 1'b1) drain_cycles++;
    checks++; if (drain_cycles !== 9) begin errors++; $display("FAIL bp_frame_cycles got %0d want 9", drain_cycles); end
    checks++; if (acc_clear !== 1'b1) begin errors++; $display("FAIL bp_clr got %b want 1", acc_clear); end
    checks++; if (sat_flag !== 1'b0)  begin errors++; $display("FAIL bp_sat got %b want 0", sat_flag); end
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_a [4];
    int exp_b [4];
    exp_a = '{1, 2, 3, -1};
    exp_b = '{-2, 3, 0, 1};
    set_lanes(16, 32, 48, -16); shift = 5'd4; out_ready = 1'b1; start = 1'b1;
    tick();
    // start stays high through the drain and must not restart the frame
    for (int k = 0; k < 4; k++) begin
      if (k == 3) start = 1'b0;
      checks++; if (out_lane !== 2'(k)) begin errors++; $display("FAIL b2b_lane beat %0d got %0d want %0d", k, out_lane, k); end
      checks++; if (out_data !== 8'(exp_a[k])) begin errors++; $display("FAIL b2b_data beat %0d got %0d want %0d", k, out_data, exp_a[k]); end
      tick();
    end
    checks++; if (acc_clear !== 1'b1) begin errors++; $display("FAIL b2b_clr got %b want 1", acc_clear); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL b2b_single_frame got busy=%b want 0", busy); end
    set_lanes(-20, 20, 0, 7); shift = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0) begin errors++; $display("FAIL b2b_second_start got valid=%b lane=%0d want 1/0", out_valid, out_lane); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== 8'(exp_b[k])) begin errors++; $display("FAIL b2b2_data beat %0d got %0d want %0d", k, out_data, exp_b[k]); end
      tick();
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    int exp_d [4];
    exp_d = '{1, -1, 3, -3};
    set_lanes(100, 200, 300, 400); shift = 5'd2; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (out_lane !== 2'd1) begin errors++; $display("FAIL rst_mid_pre lane got %0d want 1", out_lane); end
    reset_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("FAIL rst_mid_clr got %b want 0", acc_clear); end
    reset_n = 1'b1;
    tick();
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("FAIL rst_mid_clr_after got %b want 0", acc_clear); end
    set_lanes(4, -4, 12, -12); start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_lane !== 2'(k)) begin errors++; $display("FAIL rst_new_lane beat %0d got %0d want %0d", k, out_lane, k); end
      checks++; if (out_data !== 8'(exp_d[k])) begin errors++; $display("FAIL rst_new_data beat %0d got %0d want %0d", k, out_data, exp_d[k]); end
      tick();
    end
    checks++; if (acc_clear !== 1'b1) begin errors++; $display("FAIL rst_new_clr got %b want 1", acc_clear); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_shift();
    test_saturation();
    test_shift_clamp();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
